nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor that feeds one 4-bit nibble per cycle into a single instance of the team's 4-bit carry-lookahead adder, `adder_4bits`.
- Carry is registered between nibbles; result nibbles are assembled in a shift register.
- Sits between the operand register file and the datapath result bus.
- Trades latency for area against a full-width lookahead adder.
- Valid/ready handshake on both input and output.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/nibble_serial_adder_adder_4bits.sv | 30 +++
 rtl/nibble_serial_adder.sv | 104 ++++++++++
 tb/tb_nibble_serial_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the width of the nibble handled by the carry-lookahead slice each cycle.
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder_4bits.sv
// 4-bit carry-lookahead adder slice: purely combinational, all internal
// carries derived directly from generate/propagate terms and ci.
module adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. One nibble per cycle passes
// through a single adder_4bits slice; the carry is registered between
// nibbles and result nibbles are shifted in from the top of sum_reg.
// Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned CW      = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [NIB_W-1:0] nib_s;
    logic             nib_co;

    adder_4bits u_adder (
        .a  (a_reg[NIB_W-1:0]),
        .b  (b_reg[NIB_W-1:0]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    // Control FSM together with the operand/result shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            count   <= '0;
            carry   <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ^ b[WIDTH-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> NIB_W;
                    b_reg   <= b_reg >> NIB_W;
                    sum_reg <= {nib_s, sum_reg[WIDTH-1:NIB_W]};
                    carry   <= nib_co;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags from state; result fields straight from registers
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        sum       = sum_reg;
        co        = carry;
        ovf       = (a_msb == b_msb) & (sum_reg[WIDTH-1] != a_msb);
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases
// with literal expectations plus 1000 random back-to-back operations with
// random output backpressure, all scored against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned BOUND   = 200;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int unsigned      acc;
    } exp_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned n_acc    = 0;
    int unsigned n_done   = 0;
    exp_t        q[$];
    logic        ready_ctl;
    logic        rand_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out after %0d cycles", name, BOUND);
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t m;
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   r;
        if (s) begin
            r   = sx - sy;
            m.s = x - y;
            m.c = (x >= y);
        end else begin
            r   = sx + sy;
            m.s = x + y;
            m.c = ((int'(x) + int'(y)) > 65535);
        end
        m.v   = (r > 32767) || (r < -32768);
        m.acc = 0;
        return m;
    endfunction

    // out_ready is owned here: either random per cycle or the driver's value
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;
        end
    end

    // Scoreboard: record accepted ops, compare every cycle a result is shown
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            n_acc   = n_acc - q.size();
            q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(a, b, sub);
                e.acc = cyc + 1;
                q.push_back(e);
                n_acc++;
            end
            if (out_valid) begin
                chk("result_expected", 32'(q.size() != 0), 32'd1);
                chk("in_ready_low_when_done", 32'(in_ready), 32'd0);
                if (q.size() != 0) begin
                    if (!prev_ov) chk("latency", cyc - q[0].acc, NIBBLES);
                    chk("sum", 32'(sum), 32'(q[0].s));
                    chk("co", 32'(co), 32'(q[0].c));
                    chk("ovf", 32'(ovf), 32'(q[0].v));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_done++;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // Present an op and hold it until accepted; returns just after the accepting edge
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        bit ok = 0;
        a = x; b = y; sub = s; in_valid = 1'b1;
        for (int unsigned i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int unsigned i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("out_valid");
    endtask

    task automatic run_dir(input string name, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic s,
                           input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        issue(x, y, s);
        wait_valid();
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_co"}, 32'(co), 32'(ec));
        chk({name, "_ovf"}, 32'(ovf), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t m;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        ready_ctl = 1'b1; rand_mode = 1'b0;

        // Pin the model with hand-computed values
        m = model(16'h1234, 16'h4321, 1'b0);
        chk("model_add", {15'd0, m.c, m.v, m.s}, {15'd0, 1'b0, 1'b0, 16'h5555});
        m = model(16'h0005, 16'h0007, 1'b1);
        chk("model_sub", {15'd0, m.c, m.v, m.s}, {15'd0, 1'b0, 1'b0, 16'hFFFE});
        m = model(16'h8000, 16'h0001, 1'b1);
        chk("model_subovf", {15'd0, m.c, m.v, m.s}, {15'd0, 1'b1, 1'b1, 16'h7FFF});

        #12;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic add, one-cycle out_valid, ready again afterwards
        issue(16'h1234, 16'h4321, 1'b0);
        wait_valid();
        chk("t1_sum", 32'(sum), 32'h5555);
        chk("t1_co", 32'(co), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);
        chk("t1_sum_held", 32'(sum), 32'h5555);
        @(posedge clk);
        #1;

        // 2: carry ripple and signed overflow
        run_dir("t2a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir("t2b", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // 3: subtract with borrow and with overflow
        run_dir("t3a", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_dir("t3b", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // 4: backpressure with a pending op held upstream
        ready_ctl = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0);
        wait_valid();
        chk("t4_sum", 32'(sum), 32'h3333);
        @(posedge clk);
        #1;
        a = 16'h0001; b = 16'h0002; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_sum", 32'(sum), 32'h3333);
            chk("t4_no_accept", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_ctl = 1'b1;
        issue(16'h0001, 16'h0002, 1'b0);
        wait_valid();
        chk("t4_pending_sum", 32'(sum), 32'h0003);
        chk("t4_pending_co", 32'(co), 32'd0);
        @(posedge clk);
        #1;

        // 5: reset in the middle of RUN
        issue(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_co", 32'(co), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_dir("t5b", 16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // 6: random back-to-back ops with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        ready_ctl = 1'b1;
        for (int unsigned i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 32'd0);
        chk("no_drop_dup", n_done, n_acc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
